// File: rtl/board_pkg.sv
// Shared types for the two-board ships store: cell contents, game phase
// and the shot response encoding exchanged with the opponent.
package board_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        PH_PLACE = 2'd0,
        PH_PLAY  = 2'd1,
        PH_OVER  = 2'd2
    } phase_t;

    // Response codes reuse the HIT/MISS cell encoding; 00 means repeat/invalid.
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_HIT  = 2'b10;
    localparam logic [1:0] RESP_MISS = 2'b11;

endpackage

// File: rtl/board_cell_array.sv
// ROWS x COLS board of 2-bit cells: one write port, a combinational {row,col}
// lookup for control, and a registered linear-index read port for the renderer.
module board_cell_array
    import board_pkg::*;
#(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    localparam int RW   = $clog2(ROWS),
    localparam int CLW  = $clog2(COLS),
    localparam int IDXW = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CLW-1:0]  wr_col,
    input  logic [1:0]      wr_data,
    input  logic [RW-1:0]   lk_row,
    input  logic [CLW-1:0]  lk_col,
    output logic [1:0]      lk_code,
    output logic            lk_in_range,
    input  logic [IDXW-1:0] rd_idx,
    output logic [1:0]      rd_code
);

    localparam int              NCELL   = ROWS * COLS;
    localparam logic [RW-1:0]   ROW_MAX = RW'(ROWS - 1);
    localparam logic [CLW-1:0]  COL_MAX = CLW'(COLS - 1);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NCELL - 1);

    function automatic logic [IDXW-1:0] lin_idx(input logic [RW-1:0] r, input logic [CLW-1:0] c);
        return IDXW'(int'(r) * COLS + int'(c));
    endfunction

    cell_t           cells_q [NCELL];
    logic [1:0]      rd_code_q;
    logic            wr_ok;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] lk_idx;

    assign wr_ok       = wr_en && (wr_row <= ROW_MAX) && (wr_col <= COL_MAX);
    assign wr_idx      = lin_idx(wr_row, wr_col);
    assign lk_in_range = (lk_row <= ROW_MAX) && (lk_col <= COL_MAX);
    assign lk_idx      = lin_idx(lk_row, lk_col);
    // Out-of-range coordinates alias onto real cells after truncation, so mask them.
    assign lk_code     = lk_in_range ? cells_q[lk_idx] : CELL_EMPTY;
    assign rd_code     = rd_code_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < NCELL; i++) begin
                cells_q[i] <= CELL_EMPTY;
            end
            rd_code_q <= 2'b00;
        end else begin
            if (wr_ok) begin
                cells_q[wr_idx] <= cell_t'(wr_data);
            end
            rd_code_q <= (rd_idx <= IDX_MAX) ? cells_q[rd_idx] : CELL_EMPTY;
        end
    end

endmodule

// File: rtl/board_store.sv
// Ships game board store: host fleet board answering opponent shots, guest map
// recording our own shot results, plus placement/play/over sequencing.
module board_store
    import board_pkg::*;
#(
    parameter int ROWS  = 10,
    parameter int COLS  = 10,
    parameter int SHIPS = 10,
    localparam int RW   = $clog2(ROWS),
    localparam int CLW  = $clog2(COLS),
    localparam int IDXW = $clog2(ROWS * COLS),
    localparam int CNTW = $clog2(SHIPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic              place_req,
    input  logic [RW+CLW-1:0] place_xy,
    output logic              place_err,
    input  logic              shot_in_valid,
    input  logic [RW+CLW-1:0] shot_in_xy,
    output logic              shot_in_ready,
    output logic              resp_valid,
    output logic [1:0]        resp_code,
    input  logic              own_res_valid,
    input  logic [RW+CLW-1:0] own_res_xy,
    input  logic [1:0]        own_res_code,
    input  logic [IDXW-1:0]   rd_host_idx,
    output logic [1:0]        rd_host_code,
    input  logic [IDXW-1:0]   rd_guest_idx,
    output logic [1:0]        rd_guest_code,
    output logic [CNTW-1:0]   ship_count,
    output logic [CNTW-1:0]   hits_taken,
    output logic              game_over,
    output logic [1:0]        phase
);

    localparam logic [CNTW-1:0] SHIPS_C = CNTW'(SHIPS);

    phase_t          phase_q, phase_d;
    logic [CNTW-1:0] ship_cnt_q, ship_cnt_d;
    logic [CNTW-1:0] hits_q, hits_d;
    logic            place_err_q, place_err_d;
    logic            resp_valid_q, resp_valid_d;
    logic [1:0]      resp_code_q, resp_code_d;

    logic [RW-1:0]   host_row;
    logic [CLW-1:0]  host_col;
    logic [1:0]      host_lk_code;
    logic            host_in_range;
    logic            host_wr_en;
    logic [1:0]      host_wr_data;
    logic            guest_wr_en;
    logic [1:0]      guest_lk_code;
    logic            guest_in_range;
    logic            guest_lk_unused;
    logic            shot_accept;

    // The host board is addressed by placement in PLACE and by the incoming shot otherwise.
    assign host_row = (phase_q == PH_PLACE) ? place_xy[RW+CLW-1:CLW] : shot_in_xy[RW+CLW-1:CLW];
    assign host_col = (phase_q == PH_PLACE) ? place_xy[CLW-1:0]      : shot_in_xy[CLW-1:0];

    assign shot_in_ready   = (phase_q == PH_PLAY) && !resp_valid_q;
    assign shot_accept     = shot_in_valid && shot_in_ready;
    assign guest_lk_unused = ^guest_lk_code;

    always_comb begin
        phase_d      = phase_q;
        ship_cnt_d   = ship_cnt_q;
        hits_d       = hits_q;
        place_err_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_code_d  = RESP_NONE;
        host_wr_en   = 1'b0;
        host_wr_data = CELL_EMPTY;
        guest_wr_en  = 1'b0;

        case (phase_q)
            PH_PLACE: begin
                if (place_req) begin
                    if (host_in_range && host_lk_code == CELL_EMPTY && ship_cnt_q != SHIPS_C) begin
                        host_wr_en   = 1'b1;
                        host_wr_data = CELL_SHIP;
                        ship_cnt_d   = ship_cnt_q + 1'b1;
                    end else begin
                        place_err_d = 1'b1;
                    end
                end
                if (ship_cnt_q == SHIPS_C) begin
                    phase_d = PH_PLAY;
                end
            end
            PH_PLAY: begin
                if (shot_accept) begin
                    resp_valid_d = 1'b1;
                    if (host_in_range && host_lk_code == CELL_EMPTY) begin
                        resp_code_d  = RESP_MISS;
                        host_wr_en   = 1'b1;
                        host_wr_data = CELL_MISS;
                    end else if (host_in_range && host_lk_code == CELL_SHIP) begin
                        resp_code_d  = RESP_HIT;
                        host_wr_en   = 1'b1;
                        host_wr_data = CELL_HIT;
                        hits_d       = (hits_q == SHIPS_C) ? hits_q : hits_q + 1'b1;
                        if (hits_d == SHIPS_C) begin
                            phase_d = PH_OVER;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (phase_q != PH_PLACE && own_res_valid && own_res_code != RESP_NONE && guest_in_range) begin
            guest_wr_en = 1'b1;
        end

        if (new_game) begin
            phase_d      = PH_PLACE;
            ship_cnt_d   = '0;
            hits_d       = '0;
            place_err_d  = 1'b0;
            resp_valid_d = 1'b0;
            resp_code_d  = RESP_NONE;
            host_wr_en   = 1'b0;
            guest_wr_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q      <= PH_PLACE;
            ship_cnt_q   <= '0;
            hits_q       <= '0;
            place_err_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RESP_NONE;
        end else begin
            phase_q      <= phase_d;
            ship_cnt_q   <= ship_cnt_d;
            hits_q       <= hits_d;
            place_err_q  <= place_err_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
        end
    end

    board_cell_array #(.ROWS(ROWS), .COLS(COLS)) u_host (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (new_game),
        .wr_en       (host_wr_en),
        .wr_row      (host_row),
        .wr_col      (host_col),
        .wr_data     (host_wr_data),
        .lk_row      (host_row),
        .lk_col      (host_col),
        .lk_code     (host_lk_code),
        .lk_in_range (host_in_range),
        .rd_idx      (rd_host_idx),
        .rd_code     (rd_host_code)
    );

    board_cell_array #(.ROWS(ROWS), .COLS(COLS)) u_guest (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (new_game),
        .wr_en       (guest_wr_en),
        .wr_row      (own_res_xy[RW+CLW-1:CLW]),
        .wr_col      (own_res_xy[CLW-1:0]),
        .wr_data     (own_res_code),
        .lk_row      (own_res_xy[RW+CLW-1:CLW]),
        .lk_col      (own_res_xy[CLW-1:0]),
        .lk_code     (guest_lk_code),
        .lk_in_range (guest_in_range),
        .rd_idx      (rd_guest_idx),
        .rd_code     (rd_guest_code)
    );

    assign place_err  = place_err_q;
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;
    assign ship_count = ship_cnt_q;
    assign hits_taken = hits_q;
    assign game_over  = (phase_q == PH_OVER);
    assign phase      = phase_q;

endmodule

// File: tb/tb_board_store.sv
// Scenario bench for board_store: a plain array model of both boards and the
// game counters predicts every placement, shot response and board read.
module tb_board_store;

    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int SHIPS = 10;

    logic       clk = 1'b0;
    logic       rst_n, new_game, place_req, place_err;
    logic [7:0] place_xy, shot_in_xy, own_res_xy;
    logic       shot_in_valid, shot_in_ready, resp_valid, own_res_valid, game_over;
    logic [1:0] resp_code, own_res_code, rd_host_code, rd_guest_code, phase;
    logic [6:0] rd_host_idx, rd_guest_idx;
    logic [3:0] ship_count, hits_taken;

    board_store #(.ROWS(ROWS), .COLS(COLS), .SHIPS(SHIPS)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .place_req(place_req), .place_xy(place_xy), .place_err(place_err),
        .shot_in_valid(shot_in_valid), .shot_in_xy(shot_in_xy), .shot_in_ready(shot_in_ready),
        .resp_valid(resp_valid), .resp_code(resp_code),
        .own_res_valid(own_res_valid), .own_res_xy(own_res_xy), .own_res_code(own_res_code),
        .rd_host_idx(rd_host_idx), .rd_host_code(rd_host_code),
        .rd_guest_idx(rd_guest_idx), .rd_guest_code(rd_guest_code),
        .ship_count(ship_count), .hits_taken(hits_taken),
        .game_over(game_over), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: cell codes 0 empty, 1 ship, 2 hit, 3 miss; phase 0 place, 1 play, 2 over.
    int host_m [ROWS*COLS];
    int guest_m[ROWS*COLS];
    int ships_m, hits_m, phase_m;
    int fleet_r[SHIPS];
    int fleet_c[SHIPS];
    int checks = 0;
    int fails  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROWS*COLS; i++) begin
            host_m[i]  = 0;
            guest_m[i] = 0;
        end
        ships_m = 0;
        hits_m  = 0;
        phase_m = 0;
    endtask

    task automatic model_shot(input int r, input int c, output int code);
        code = 0;
        if (r < ROWS && c < COLS) begin
            if (host_m[r*COLS+c] == 0) begin
                host_m[r*COLS+c] = 3;
                code = 3;
            end else if (host_m[r*COLS+c] == 1) begin
                host_m[r*COLS+c] = 2;
                code = 2;
                if (hits_m < SHIPS) hits_m++;
                if (hits_m == SHIPS) phase_m = 2;
            end
        end
    endtask

    task automatic make_fleet(input int r0, input int c0);
        int r, c;
        bit dup;
        fleet_r[0] = r0;
        fleet_c[0] = c0;
        for (int k = 1; k < SHIPS; k++) begin
            do begin
                r = $urandom_range(0, ROWS-1);
                c = $urandom_range(0, COLS-1);
                dup = (r == 0 && c == 0);
                for (int j = 0; j < k; j++) if (fleet_r[j] == r && fleet_c[j] == c) dup = 1;
            end while (dup);
            fleet_r[k] = r;
            fleet_c[k] = c;
        end
    endtask

    task automatic place_cell(input int r, input int c);
        bit ok;
        ok = (r < ROWS) && (c < COLS) && (ships_m < SHIPS) && (host_m[r*COLS+c] == 0);
        place_req = 1'b1;
        place_xy  = {r[3:0], c[3:0]};
        tick();
        place_req = 1'b0;
        if (ok) begin
            host_m[r*COLS+c] = 1;
            ships_m++;
        end
        checks++;
        if (place_err !== !ok) begin
            fails++;
            $display("FAIL place_err r=%0d c=%0d got %b want %b", r, c, place_err, !ok);
        end
        checks++;
        if (ship_count !== ships_m[3:0]) begin
            fails++;
            $display("FAIL ship_count r=%0d c=%0d got %0d want %0d", r, c, ship_count, ships_m);
        end
        $display("place r=%0d c=%0d err=%b count=%0d", r, c, place_err, ship_count);
    endtask

    task automatic shoot(input int r, input int c);
        int  code;
        bit  acc;
        acc = (phase_m == 1);
        checks++;
        if (shot_in_ready !== acc) begin
            fails++;
            $display("FAIL shot_ready_pre r=%0d c=%0d got %b want %b", r, c, shot_in_ready, acc);
        end
        shot_in_valid = 1'b1;
        shot_in_xy    = {r[3:0], c[3:0]};
        tick();
        shot_in_valid = 1'b0;
        code = 0;
        if (acc) model_shot(r, c, code);
        checks++;
        if (resp_valid !== acc || (acc && resp_code !== code[1:0])) begin
            fails++;
            $display("FAIL shot_resp r=%0d c=%0d got v=%b code=%b want v=%b code=%b",
                     r, c, resp_valid, resp_code, acc, code[1:0]);
        end
        checks++;
        if (hits_taken !== hits_m[3:0] || phase !== phase_m[1:0] || game_over !== (phase_m == 2)
            || shot_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL shot_state r=%0d c=%0d got hits=%0d ph=%0d go=%b rdy=%b want hits=%0d ph=%0d",
                     r, c, hits_taken, phase, game_over, shot_in_ready, hits_m, phase_m);
        end
        $display("shot r=%0d c=%0d resp_v=%b code=%b hits=%0d", r, c, resp_valid, resp_code, hits_taken);
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL resp_one_pulse got %b want 0", resp_valid);
        end
    endtask

    task automatic read_all_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < ROWS*COLS + 2; i++) begin
            int idx, eh, eg;
            idx = (i < ROWS*COLS) ? i : (i == ROWS*COLS ? ROWS*COLS : 127);
            eh  = (idx < ROWS*COLS) ? host_m[idx]  : 0;
            eg  = (idx < ROWS*COLS) ? guest_m[idx] : 0;
            rd_host_idx  = idx[6:0];
            rd_guest_idx = idx[6:0];
            tick();
            checks++;
            if (rd_host_code !== eh[1:0] || rd_guest_code !== eg[1:0]) begin
                fails++;
                bad++;
                $display("FAIL read_%s idx=%0d got host=%b guest=%b want host=%b guest=%b",
                         tag, idx, rd_host_code, rd_guest_code, eh[1:0], eg[1:0]);
            end
        end
        $display("read_all %s cells=%0d bad=%0d", tag, ROWS*COLS + 2, bad);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; new_game = 1'b0; place_req = 1'b0; place_xy = '0;
        shot_in_valid = 1'b0; shot_in_xy = '0; own_res_valid = 1'b0; own_res_xy = '0;
        own_res_code = '0; rd_host_idx = '0; rd_guest_idx = '0;
        tick();
        tick();
        model_clear();
        checks++;
        if (phase !== 2'd0 || ship_count !== 4'd0 || hits_taken !== 4'd0 || game_over !== 1'b0 ||
            shot_in_ready !== 1'b0 || resp_valid !== 1'b0 || place_err !== 1'b0 ||
            rd_host_code !== 2'b00 || rd_guest_code !== 2'b00) begin
            fails++;
            $display("FAIL reset_state got ph=%0d cnt=%0d hits=%0d go=%b rdy=%b rv=%b pe=%b want all 0",
                     phase, ship_count, hits_taken, game_over, shot_in_ready, resp_valid, place_err);
        end
        $display("reset ph=%0d cnt=%0d", phase, ship_count);
        rst_n = 1'b1;
    endtask

    task automatic test_place_errors();
        place_cell(2, 3);
        place_cell(2, 3);
        place_cell(12, 3);
        place_cell(3, 10);
        tick();
        checks++;
        if (place_err !== 1'b0) begin
            fails++;
            $display("FAIL place_err_pulse got %b want 0", place_err);
        end
    endtask

    task automatic test_place_rest();
        for (int k = 1; k < SHIPS; k++) place_cell(fleet_r[k], fleet_c[k]);
        checks++;
        if (phase !== 2'd0) begin
            fails++;
            $display("FAIL phase_after_last_place got %0d want 0", phase);
        end
        tick();
        phase_m = 1;
        checks++;
        if (phase !== 2'd1 || shot_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL phase_play got ph=%0d rdy=%b want ph=1 rdy=1", phase, shot_in_ready);
        end
        read_all_check("placed");
    endtask

    task automatic test_shots();
        shoot(2, 3);
        shoot(2, 3);
        shoot(0, 0);
        shoot(11, 4);
    endtask

    task automatic test_back_to_back();
        int tr[6], tc[6];
        int tgt, pending, nresp, code, cyc;
        bit exp_rdy, take, is_ship;
        for (int k = 0; k < 6; k++) begin
            do begin
                tr[k] = $urandom_range(0, 13);
                tc[k] = $urandom_range(0, 11);
                is_ship = 0;
                for (int j = 0; j < SHIPS; j++) if (fleet_r[j] == tr[k] && fleet_c[j] == tc[k]) is_ship = 1;
            end while (is_ship);
        end
        tgt = 0; pending = 0; nresp = 0; cyc = 0;
        shot_in_valid = 1'b1;
        shot_in_xy    = {tr[0][3:0], tc[0][3:0]};
        while ((tgt < 6 || pending != 0) && cyc < 40) begin
            exp_rdy = (phase_m == 1) && (pending == 0);
            checks++;
            if (shot_in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL b2b_ready cyc=%0d got %b want %b", cyc, shot_in_ready, exp_rdy);
            end
            take = shot_in_valid && exp_rdy;
            code = 0;
            if (take) model_shot(tr[tgt], tc[tgt], code);
            tick();
            if (resp_valid === 1'b1) nresp++;
            checks++;
            if (resp_valid !== take || (take && resp_code !== code[1:0])) begin
                fails++;
                $display("FAIL b2b_resp cyc=%0d got v=%b code=%b want v=%b code=%b",
                         cyc, resp_valid, resp_code, take, code[1:0]);
            end
            $display("b2b cyc=%0d rdy=%b take=%b resp_v=%b code=%b", cyc, exp_rdy, take, resp_valid, resp_code);
            pending = take ? 1 : 0;
            if (take) tgt++;
            shot_in_valid = (tgt < 6);
            if (tgt < 6) shot_in_xy = {tr[tgt][3:0], tc[tgt][3:0]};
            cyc++;
        end
        shot_in_valid = 1'b0;
        checks++;
        if (nresp != 6 || tgt != 6) begin
            fails++;
            $display("FAIL b2b_count got resp=%0d accepted=%0d want 6/6", nresp, tgt);
        end
        tick();
    endtask

    task automatic test_game_over();
        for (int k = 1; k < SHIPS; k++) shoot(fleet_r[k], fleet_c[k]);
        checks++;
        if (game_over !== 1'b1 || phase !== 2'd2 || shot_in_ready !== 1'b0 || hits_taken !== 4'd10) begin
            fails++;
            $display("FAIL game_over got go=%b ph=%0d rdy=%b hits=%0d want 1/2/0/10",
                     game_over, phase, shot_in_ready, hits_taken);
        end
        shoot(0, 5);
        own_res_valid = 1'b1; own_res_xy = 8'h11; own_res_code = 2'b11;
        tick();
        own_res_valid = 1'b0;
        guest_m[11] = 3;
        read_all_check("over");
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        checks++;
        if (phase !== 2'd0 || ship_count !== 4'd0 || hits_taken !== 4'd0 || game_over !== 1'b0 ||
            resp_valid !== 1'b0 || place_err !== 1'b0) begin
            fails++;
            $display("FAIL new_game_state got ph=%0d cnt=%0d hits=%0d go=%b want 0", phase, ship_count,
                     hits_taken, game_over);
        end
        read_all_check("new_game");
    endtask

    task automatic test_own_res();
        int code, old_g, r, c, cd;
        own_res_valid = 1'b1; own_res_xy = 8'h45; own_res_code = 2'b10;
        tick();
        own_res_valid = 1'b0;
        make_fleet(7, 7);
        for (int k = 0; k < SHIPS; k++) place_cell(fleet_r[k], fleet_c[k]);
        tick();
        phase_m = 1;
        rd_guest_idx  = 7'd45;
        shot_in_valid = 1'b1; shot_in_xy = {fleet_r[3][3:0], fleet_c[3][3:0]};
        own_res_valid = 1'b1; own_res_xy = 8'h45; own_res_code = 2'b10;
        old_g = guest_m[45];
        tick();
        shot_in_valid = 1'b0; own_res_valid = 1'b0;
        model_shot(fleet_r[3], fleet_c[3], code);
        guest_m[45] = 2;
        checks++;
        if (resp_valid !== 1'b1 || resp_code !== code[1:0] || hits_taken !== hits_m[3:0]) begin
            fails++;
            $display("FAIL concurrent_resp got v=%b code=%b hits=%0d want 1/%b/%0d",
                     resp_valid, resp_code, hits_taken, code[1:0], hits_m);
        end
        checks++;
        if (rd_guest_code !== old_g[1:0]) begin
            fails++;
            $display("FAIL read_old_value got %b want %b", rd_guest_code, old_g[1:0]);
        end
        tick();
        checks++;
        if (rd_guest_code !== 2'b10) begin
            fails++;
            $display("FAIL guest_45 got %b want 10", rd_guest_code);
        end
        $display("own_res idx=45 code=%b resp=%b", rd_guest_code, resp_code);
        for (int n = 0; n < 24; n++) begin
            r  = (n == 0) ? 4 : $urandom_range(0, 15);
            c  = (n == 0) ? 5 : $urandom_range(0, 15);
            cd = (n == 0) ? 0 : $urandom_range(0, 3);
            own_res_valid = 1'b1; own_res_xy = {r[3:0], c[3:0]}; own_res_code = cd[1:0];
            tick();
            if (cd != 0 && r < ROWS && c < COLS) guest_m[r*COLS+c] = cd;
        end
        own_res_valid = 1'b0;
        read_all_check("own_res");
    endtask

    task automatic test_reset_mid_play();
        rst_n = 1'b0;
        new_game = 1'b1;
        tick();
        rst_n = 1'b1;
        new_game = 1'b0;
        model_clear();
        checks++;
        if (phase !== 2'd0 || ship_count !== 4'd0 || hits_taken !== 4'd0 || shot_in_ready !== 1'b0 ||
            resp_valid !== 1'b0 || game_over !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_play got ph=%0d cnt=%0d hits=%0d rdy=%b want 0",
                     phase, ship_count, hits_taken, shot_in_ready);
        end
        read_all_check("reset_mid");
    endtask

    initial begin
        test_reset();
        make_fleet(2, 3);
        test_place_errors();
        test_place_rest();
        test_shots();
        test_back_to_back();
        test_game_over();
        test_own_res();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
